encoder_controller: RTL and testbench

FSM that sequences `EncoderDatapath` through one full 24-round encode of a 64-slice x 25-bit state. It runs load, then 24 rounds of ColParity -> Rotate -> Permutation -> Revaluate -> AddRc, then unload. It owns every datapath control strobe, including memory select/read/write, slice/cycle counter enables and clears, and sub-unit starts. It presents a simple load/unload handshake to the enclosing encoder top.

---
 rtl/encoder_controller_if.sv | 44 ++++
 rtl/encoder_controller.sv | 170 +++++++++++++++++
 tb/tb_encoder_controller.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/encoder_controller_if.sv
// Control/handshake bundle between encoder_controller (master) and the
// encoder datapath plus enclosing top (slave).
interface encoder_controller_if;
  logic       start;
  logic       colPutInput, colOutReady, colReady;
  logic       rotPutInput, rotOutReady, rotReady;
  logic       perPutInput, perReady;
  logic       revPutInput, revOutReady, revReady;
  logic       addPutInput, addReady;
  logic       sliceCntCo, cycleCntCo;
  logic [2:0] memSrc;
  logic       memRead, memWrite;
  logic       sliceCntEn, sliceCntClr, cycleCntEn, cycleCntClr;
  logic       colStart, rotStart, perStart, revStart, addStart;
  logic       putInput, outValid, busy, done;

  modport master (
    input  start,
    input  colPutInput, colOutReady, colReady,
    input  rotPutInput, rotOutReady, rotReady,
    input  perPutInput, perReady,
    input  revPutInput, revOutReady, revReady,
    input  addPutInput, addReady,
    input  sliceCntCo, cycleCntCo,
    output memSrc, memRead, memWrite,
    output sliceCntEn, sliceCntClr, cycleCntEn, cycleCntClr,
    output colStart, rotStart, perStart, revStart, addStart,
    output putInput, outValid, busy, done
  );

  modport slave (
    output start,
    output colPutInput, colOutReady, colReady,
    output rotPutInput, rotOutReady, rotReady,
    output perPutInput, perReady,
    output revPutInput, revOutReady, revReady,
    output addPutInput, addReady,
    output sliceCntCo, cycleCntCo,
    input  memSrc, memRead, memWrite,
    input  sliceCntEn, sliceCntClr, cycleCntEn, cycleCntClr,
    input  colStart, rotStart, perStart, revStart, addStart,
    input  putInput, outValid, busy, done
  );
endinterface

// File: rtl/encoder_controller.sv
// Sequencer for one 24-round encode: load, 24 x (col, rot, per, rev, add), unload.
// Moore outputs per state; slice strobes are gated by the active unit's handshake.
module encoder_controller (
  input  logic                  clk,
  input  logic                  rst_n,
  encoder_controller_if.master  bus
);

  typedef enum logic [4:0] {
    IDLE, LOAD,
    COL_S, COL_IN, COL_GAP, COL_OUT, COL_W,
    ROT_S, ROT_IN, ROT_GAP, ROT_OUT, ROT_W,
    PER_S, PER_RUN, PER_W,
    REV_S, REV_IN, REV_GAP, REV_OUT, REV_W,
    ADD_S, ADD_RUN, ADD_W,
    UL_S, UNLOAD, DONE
  } state_t;

  state_t     r_state, w_next;
  logic [2:0] w_memSrc;
  logic       w_memRead, w_memWrite;
  logic       w_sliceCntEn, w_sliceCntClr, w_cycleCntEn, w_cycleCntClr;
  logic       w_colStart, w_rotStart, w_perStart, w_revStart, w_addStart;
  logic       w_putInput, w_outValid, w_busy, w_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Phase exits on the last slice only when that slice was actually transferred.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (bus.start) w_next = LOAD;
      LOAD:    if (bus.sliceCntCo) w_next = COL_S;
      COL_S:   w_next = COL_IN;
      COL_IN:  if (bus.colPutInput && bus.sliceCntCo) w_next = COL_GAP;
      COL_GAP: w_next = COL_OUT;
      COL_OUT: if (bus.colOutReady && bus.sliceCntCo) w_next = COL_W;
      COL_W:   if (bus.colReady) w_next = ROT_S;
      ROT_S:   w_next = ROT_IN;
      ROT_IN:  if (bus.rotPutInput && bus.sliceCntCo) w_next = ROT_GAP;
      ROT_GAP: w_next = ROT_OUT;
      ROT_OUT: if (bus.rotOutReady && bus.sliceCntCo) w_next = ROT_W;
      ROT_W:   if (bus.rotReady) w_next = PER_S;
      PER_S:   w_next = PER_RUN;
      PER_RUN: if (bus.perPutInput && bus.sliceCntCo) w_next = PER_W;
      PER_W:   if (bus.perReady) w_next = REV_S;
      REV_S:   w_next = REV_IN;
      REV_IN:  if (bus.revPutInput && bus.sliceCntCo) w_next = REV_GAP;
      REV_GAP: w_next = REV_OUT;
      REV_OUT: if (bus.revOutReady && bus.sliceCntCo) w_next = REV_W;
      REV_W:   if (bus.revReady) w_next = ADD_S;
      ADD_S:   w_next = ADD_RUN;
      ADD_RUN: if (bus.addPutInput && bus.sliceCntCo) w_next = ADD_W;
      ADD_W:   if (bus.addReady) w_next = bus.cycleCntCo ? UL_S : COL_S;
      UL_S:    w_next = UNLOAD;
      UNLOAD:  if (bus.sliceCntCo) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_memSrc      = 3'd0;
    w_memRead     = 1'b0;
    w_memWrite    = 1'b0;
    w_sliceCntEn  = 1'b0;
    w_sliceCntClr = 1'b0;
    w_cycleCntEn  = 1'b0;
    w_cycleCntClr = 1'b0;
    w_colStart    = 1'b0;
    w_rotStart    = 1'b0;
    w_perStart    = 1'b0;
    w_revStart    = 1'b0;
    w_addStart    = 1'b0;
    w_putInput    = 1'b0;
    w_outValid    = 1'b0;
    w_done        = 1'b0;
    w_busy        = (r_state != IDLE);
    unique case (r_state)
      IDLE: begin
        w_sliceCntClr = 1'b1;
        w_cycleCntClr = 1'b1;
      end
      LOAD: begin
        w_putInput   = 1'b1;
        w_memWrite   = 1'b1;
        w_sliceCntEn = 1'b1;
      end
      COL_S:   begin w_colStart = 1'b1; w_sliceCntClr = 1'b1; end
      ROT_S:   begin w_rotStart = 1'b1; w_sliceCntClr = 1'b1; end
      PER_S:   begin w_perStart = 1'b1; w_sliceCntClr = 1'b1; end
      REV_S:   begin w_revStart = 1'b1; w_sliceCntClr = 1'b1; end
      ADD_S:   begin w_addStart = 1'b1; w_sliceCntClr = 1'b1; end
      COL_GAP, ROT_GAP, REV_GAP: w_sliceCntClr = 1'b1;
      COL_IN: begin
        w_memRead    = bus.colPutInput;
        w_sliceCntEn = bus.colPutInput;
      end
      ROT_IN: begin
        w_memRead    = bus.rotPutInput;
        w_sliceCntEn = bus.rotPutInput;
      end
      REV_IN: begin
        w_memRead    = bus.revPutInput;
        w_sliceCntEn = bus.revPutInput;
      end
      COL_OUT: begin
        w_memSrc     = 3'd1;
        w_memWrite   = bus.colOutReady;
        w_sliceCntEn = bus.colOutReady;
      end
      ROT_OUT: begin
        w_memSrc     = 3'd2;
        w_memWrite   = bus.rotOutReady;
        w_sliceCntEn = bus.rotOutReady;
      end
      REV_OUT: begin
        w_memSrc     = 3'd4;
        w_memWrite   = bus.revOutReady;
        w_sliceCntEn = bus.revOutReady;
      end
      // In-place units read and write back the same slice in one cycle.
      PER_RUN: begin
        w_memSrc     = 3'd3;
        w_memRead    = bus.perPutInput;
        w_memWrite   = bus.perPutInput;
        w_sliceCntEn = bus.perPutInput;
      end
      ADD_RUN: begin
        w_memSrc     = 3'd5;
        w_memRead    = bus.addPutInput;
        w_memWrite   = bus.addPutInput;
        w_sliceCntEn = bus.addPutInput;
      end
      ADD_W: w_cycleCntEn = bus.addReady && !bus.cycleCntCo;
      UL_S: begin
        w_sliceCntClr = 1'b1;
        w_cycleCntClr = 1'b1;
      end
      UNLOAD: begin
        w_memRead    = 1'b1;
        w_outValid   = 1'b1;
        w_sliceCntEn = 1'b1;
      end
      DONE: w_done = 1'b1;
      default: ;
    endcase
  end

  assign bus.memSrc      = w_memSrc;
  assign bus.memRead     = w_memRead;
  assign bus.memWrite    = w_memWrite;
  assign bus.sliceCntEn  = w_sliceCntEn;
  assign bus.sliceCntClr = w_sliceCntClr;
  assign bus.cycleCntEn  = w_cycleCntEn;
  assign bus.cycleCntClr = w_cycleCntClr;
  assign bus.colStart    = w_colStart;
  assign bus.rotStart    = w_rotStart;
  assign bus.perStart    = w_perStart;
  assign bus.revStart    = w_revStart;
  assign bus.addStart    = w_addStart;
  assign bus.putInput    = w_putInput;
  assign bus.outValid    = w_outValid;
  assign bus.busy        = w_busy;
  assign bus.done        = w_done;

endmodule

// File: tb/tb_encoder_controller.sv
// Directed bench for encoder_controller with behavioural slice/round counters
// and ideal unit models (64 reads, 64 writes, ready one cycle later).
module tb_encoder_controller;

  logic clk = 1'b0;
  logic rst_n;
  logic start;

  always #5 clk = ~clk;

  encoder_controller_if bus();
  assign bus.start = start;

  encoder_controller u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Datapath counters: clear wins, carry-outs are combinational on the count.
  logic [5:0] sliceCnt = '0;
  logic [4:0] cycleCnt = '0;
  always @(posedge clk) begin
    if (bus.sliceCntClr)     sliceCnt <= '0;
    else if (bus.sliceCntEn) sliceCnt <= sliceCnt + 6'd1;
    if (bus.cycleCntClr)     cycleCnt <= '0;
    else if (bus.cycleCntEn) cycleCnt <= cycleCnt + 5'd1;
  end
  assign bus.sliceCntCo = (sliceCnt == 6'd63);
  assign bus.cycleCntCo = (cycleCnt == 5'd23);

  // Unit index: 0 col, 1 rot, 2 per, 3 rev, 4 add. ph: 0 idle, 1 in, 2 out, 3 ready.
  logic [1:0] ph [5];
  int         inCnt [5];
  int         outCnt [5];
  logic [4:0] uStart, uPut, uOut, uReady;
  logic       stallArm = 1'b0;
  int         stallLeft;
  logic       stallActive;

  assign uStart = {bus.addStart, bus.revStart, bus.perStart, bus.rotStart, bus.colStart};
  assign stallActive = stallArm && (ph[1] == 2'd2) && (outCnt[1] == 30) && (stallLeft != 0);

  always_comb begin
    for (int u = 0; u < 5; u++) begin
      uPut[u]   = (ph[u] == 2'd1);
      uOut[u]   = (ph[u] == 2'd2);
      uReady[u] = (ph[u] == 2'd3);
    end
    uOut[1] = uOut[1] && !stallActive;
  end

  assign bus.colPutInput = uPut[0];
  assign bus.colOutReady = uOut[0];
  assign bus.colReady    = uReady[0];
  assign bus.rotPutInput = uPut[1];
  assign bus.rotOutReady = uOut[1];
  assign bus.rotReady    = uReady[1];
  assign bus.perPutInput = uPut[2];
  assign bus.perReady    = uReady[2];
  assign bus.revPutInput = uPut[3];
  assign bus.revOutReady = uOut[3];
  assign bus.revReady    = uReady[3];
  assign bus.addPutInput = uPut[4];
  assign bus.addReady    = uReady[4];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int u = 0; u < 5; u++) begin
        ph[u]     <= 2'd0;
        inCnt[u]  <= 0;
        outCnt[u] <= 0;
      end
      stallLeft <= 10;
    end else begin
      if (!stallArm)        stallLeft <= 10;
      else if (stallActive) stallLeft <= stallLeft - 1;
      for (int u = 0; u < 5; u++) begin
        if (uStart[u]) begin
          ph[u]     <= 2'd1;
          inCnt[u]  <= 0;
          outCnt[u] <= 0;
        end else if (ph[u] == 2'd1 && uPut[u] && bus.memRead) begin
          inCnt[u] <= inCnt[u] + 1;
          if (inCnt[u] == 63) ph[u] <= (u == 2 || u == 4) ? 2'd3 : 2'd2;
        end else if (ph[u] == 2'd2 && uOut[u] && bus.memWrite) begin
          outCnt[u] <= outCnt[u] + 1;
          if (outCnt[u] == 63) ph[u] <= 2'd3;
        end
      end
    end
  end

  // Event tallies, sampled on the falling edge.
  int cyc = 0, nPut = 0, nAddStart = 0, nCycEn = 0, nOutValid = 0, nDone = 0;
  int lastOvCyc = 0, doneCyc = 0, nRd = 0, nStallCyc = 0, nStallViol = 0;
  int stallSlice = -1, nConflict = 0;
  int nWr [8] = '{default: 0};
  int startQ [$];

  always @(negedge clk) begin
    cyc++;
    if (bus.putInput)   nPut++;
    if (bus.addStart)   nAddStart++;
    if (bus.cycleCntEn) nCycEn++;
    if (bus.memRead)    nRd++;
    if (bus.memWrite)   nWr[bus.memSrc]++;
    if (bus.outValid) begin nOutValid++; lastOvCyc = cyc; end
    if (bus.done)     begin nDone++;     doneCyc = cyc;   end
    if (bus.colStart) startQ.push_back(1);
    if (bus.rotStart) startQ.push_back(2);
    if (bus.perStart) startQ.push_back(3);
    if (bus.revStart) startQ.push_back(4);
    if (bus.addStart) startQ.push_back(5);
    if (stallActive) begin
      nStallCyc++;
      stallSlice = int'(sliceCnt);
      if (bus.memWrite || bus.sliceCntEn) nStallViol++;
    end
    if ((bus.sliceCntClr && bus.sliceCntEn) || (bus.cycleCntClr && bus.cycleCntEn)) nConflict++;
  end

  int nTests = 0;
  int nFail  = 0;

  task automatic checkOutput(input string tag, input int got, input int exp);
    nTests++;
    if (got != exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input int cycles);
    start = s;
    repeat (cycles) begin
      @(negedge clk);
      #1;
    end
  endtask

  function automatic int wrSum();
    int s = 0;
    for (int i = 0; i < 8; i++) s += nWr[i];
    return s;
  endfunction

  task automatic waitDone(input int budget, input bit inject);
    int n = 0;
    while (!bus.done && n < budget) begin
      @(negedge clk);
      #1;
      if (inject) start = (cycleCnt == 5'd4);
      n++;
    end
    checkOutput("doneSeen", int'(bus.done), 1);
  endtask

  int sPut, sAdd, sCyc, sOv, sDone, sRd, sStall, sViol, sW0;
  int sWr [8];
  int wBefore, n, seq;

  task automatic snap();
    sPut = nPut; sAdd = nAddStart; sCyc = nCycEn; sOv = nOutValid;
    sDone = nDone; sRd = nRd; sStall = nStallCyc; sViol = nStallViol;
    for (int i = 0; i < 8; i++) sWr[i] = nWr[i];
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rstBusy",     int'(bus.busy), 0);
    checkOutput("rstSliceClr", int'(bus.sliceCntClr), 1);
    checkOutput("rstCycClr",   int'(bus.cycleCntClr), 1);
    checkOutput("rstStarts",   int'(uStart), 0);
    checkOutput("rstMemSrc",   int'(bus.memSrc), 0);
    checkOutput("rstMemWrite", int'(bus.memWrite), 0);
    checkOutput("rstDone",     int'(bus.done), 0);

    rst_n = 1'b1;
    applyStimulus(1'b0, 1);
    checkOutput("idleBusy",    int'(bus.busy), 0);
    checkOutput("idleSliceClr",int'(bus.sliceCntClr), 1);
    checkOutput("idlePut",     int'(bus.putInput), 0);

    // Encode 1: full run, with start re-asserted during round 5.
    snap();
    applyStimulus(1'b1, 1);
    start = 1'b0;
    checkOutput("loadPut",     int'(bus.putInput), 1);
    checkOutput("loadMemSrc",  int'(bus.memSrc), 0);
    checkOutput("loadMemWrite",int'(bus.memWrite), 1);
    checkOutput("loadBusy",    int'(bus.busy), 1);
    waitDone(20000, 1'b1);
    start = 1'b0;
    checkOutput("e1PutCycles", nPut - sPut, 64);
    checkOutput("e1LoadWr",    nWr[0] - sWr[0], 64);
    checkOutput("e1AddStarts", nAddStart - sAdd, 24);
    checkOutput("e1CycEn",     nCycEn - sCyc, 23);
    checkOutput("e1OutValid",  nOutValid - sOv, 64);
    checkOutput("e1Done",      nDone - sDone, 1);
    checkOutput("e1DoneLag",   doneCyc - lastOvCyc, 1);
    checkOutput("e1ColWr",     nWr[1] - sWr[1], 1536);
    checkOutput("e1RotWr",     nWr[2] - sWr[2], 1536);
    checkOutput("e1PerWr",     nWr[3] - sWr[3], 1536);
    checkOutput("e1RevWr",     nWr[4] - sWr[4], 1536);
    checkOutput("e1AddWr",     nWr[5] - sWr[5], 1536);
    checkOutput("e1BadSrcWr",  nWr[6] + nWr[7], 0);
    checkOutput("e1Reads",     nRd - sRd, 7744);
    seq = 0;
    for (int i = 0; i < 5; i++) seq = seq * 8 + ((startQ.size() > i) ? startQ[i] : 0);
    checkOutput("startOrder",  seq, 'o12345);
    applyStimulus(1'b0, 1);
    checkOutput("postDoneBusy", int'(bus.busy), 0);

    // Encode 2: rot output stall in round 1, reset in REV_OUT slice 12 of round 3.
    stallArm = 1'b1;
    snap();
    applyStimulus(1'b1, 1);
    start = 1'b0;
    n = 0;
    while (!(ph[3] == 2'd2 && outCnt[3] == 12 && cycleCnt == 5'd2) && n < 20000) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput("reachRevOut12", int'(ph[3] == 2'd2 && outCnt[3] == 12), 1);
    checkOutput("stallCycles",  nStallCyc - sStall, 10);
    checkOutput("stallViol",    nStallViol - sViol, 0);
    checkOutput("stallSlice",   stallSlice, 30);
    checkOutput("e2RotWr",      nWr[2] - sWr[2], 192);
    checkOutput("e2ColWr",      nWr[1] - sWr[1], 192);
    rst_n = 1'b0;
    #1;
    checkOutput("midRstBusy",   int'(bus.busy), 0);
    checkOutput("midRstWrite",  int'(bus.memWrite), 0);
    checkOutput("midRstSlEn",   int'(bus.sliceCntEn), 0);
    checkOutput("midRstMemSrc", int'(bus.memSrc), 0);
    checkOutput("midRstCycClr", int'(bus.cycleCntClr), 1);
    wBefore = wrSum();
    stallArm = 1'b0;
    applyStimulus(1'b0, 3);
    checkOutput("rstNoWrites",  wrSum() - wBefore, 0);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1);

    // Encode 3: start held high throughout, so a second encode follows DONE.
    snap();
    applyStimulus(1'b1, 1);
    checkOutput("e3LoadPut",    int'(bus.putInput), 1);
    checkOutput("e3CycCleared", int'(cycleCnt), 0);
    waitDone(20000, 1'b0);
    checkOutput("e3AddStarts",  nAddStart - sAdd, 24);
    checkOutput("e3CycEn",      nCycEn - sCyc, 23);
    applyStimulus(1'b1, 1);
    checkOutput("b2bIdleBusy",  int'(bus.busy), 0);
    checkOutput("b2bIdleClr",   int'(bus.cycleCntClr), 1);
    applyStimulus(1'b1, 1);
    checkOutput("b2bLoadPut",   int'(bus.putInput), 1);
    checkOutput("b2bLoadBusy",  int'(bus.busy), 1);
    start = 1'b0;

    checkOutput("clrEnConflict", nConflict, 0);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
